timer_tick_sched: RTL

//  Sequences the four cascaded hardware timers. Decodes each TMxCNT_H control word and

---
 rtl/timer_pkg.sv | 31 +++
 rtl/timer_prescaler.sv | 41 ++++
 rtl/timer_tick_sched.sv | 80 ++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared timer definitions: prescaler select, TMxCNT_H bit positions, divide lookup.
// Used by the tick scheduler, the timer counters and the MMIO decode.
package timer_pkg;

  localparam int TIMER_PRESC_W   = 10;

  localparam int TMCNT_H_PSEL    = 0;  // two bits wide
  localparam int TMCNT_H_CASCADE = 2;
  localparam int TMCNT_H_IRQEN   = 6;
  localparam int TMCNT_H_ENABLE  = 7;

  typedef enum logic [1:0] {
    PS_1    = 2'd0,
    PS_64   = 2'd1,
    PS_256  = 2'd2,
    PS_1024 = 2'd3
  } prescale_t;

  function automatic logic [TIMER_PRESC_W-1:0] div_minus1(input prescale_t ps);
    logic [TIMER_PRESC_W-1:0] r;
    r = '0;
    case (ps)
      PS_1:    r = TIMER_PRESC_W'(0);
      PS_64:   r = TIMER_PRESC_W'(63);
      PS_256:  r = TIMER_PRESC_W'(255);
      PS_1024: r = TIMER_PRESC_W'(1023);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Per-timer free-running prescaler; emits presc_tick once every div cycles of counting.
// The divide is looked up from the live psel so a rewrite takes effect immediately.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int PRESC_W = 10
) (
  input  logic      clock_16,
  input  logic      reset,
  input  logic      enable,
  input  logic      start,
  input  prescale_t psel,
  input  logic      hold,
  output logic      presc_tick
);

  logic [PRESC_W-1:0] cnt_q, cnt_d, lim;
  logic               wrap;

  // Comparing with >= lets a shrink of div below the current count wrap at once.
  always_comb begin
    lim        = PRESC_W'(div_minus1(psel));
    wrap       = (cnt_q >= lim);
    presc_tick = enable & ~start & ~hold & wrap;
    cnt_d      = cnt_q;
    if (!enable || start) begin
      cnt_d = '0;
    end else if (!hold) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock_16) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/timer_tick_sched.sv
// Tick/load/irq sequencer for the cascaded timers. Build with TIMER_FREEZE_EN to get
// the debug freeze port; without it the block behaves as if freeze were tied low.
module timer_tick_sched
  import timer_pkg::*;
#(
  parameter int NUM_TIMERS = 4,
  parameter int PRESC_W    = 10
) (
  input  logic                       clock_16,
  input  logic                       reset,
  input  logic [NUM_TIMERS-1:0][15:0] tmcnt_h,
  input  logic [NUM_TIMERS-1:0]      overflow,
`ifdef TIMER_FREEZE_EN
  input  logic                       freeze,
`endif
  output logic [NUM_TIMERS-1:0]      tick,
  output logic [NUM_TIMERS-1:0]      load,
  output logic [NUM_TIMERS-1:0]      irq
);

  logic [NUM_TIMERS-1:0] enable, start, presc_tick, casc_tick;
  logic [NUM_TIMERS-1:0] en_q, en_d, ovf_q, ovf_d;
  logic                  frz;

`ifdef TIMER_FREEZE_EN
  assign frz = freeze;
`else
  assign frz = 1'b0;
`endif

  assign start = enable & ~en_q;
  assign load  = start;
  assign en_d  = enable;
  // A frozen chain keeps its pending overflow so nothing is lost across the halt.
  assign ovf_d = frz ? ovf_q : overflow;

  always_ff @(posedge clock_16) begin
    if (reset) begin
      en_q  <= '0;
      ovf_q <= '0;
    end else begin
      en_q  <= en_d;
      ovf_q <= ovf_d;
    end
  end

  for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_tmr
    logic      irq_en, casc_eff, unused_bits;
    prescale_t psel;

    assign enable[g] = tmcnt_h[g][TMCNT_H_ENABLE];
    assign irq_en    = tmcnt_h[g][TMCNT_H_IRQEN];
    assign psel      = prescale_t'(tmcnt_h[g][TMCNT_H_PSEL +: 2]);

    if (g == 0) begin : g_head
      assign casc_eff     = 1'b0;
      assign casc_tick[g] = 1'b0;
      assign unused_bits  = ^{tmcnt_h[g][15:8], tmcnt_h[g][5:2]};
    end else begin : g_chain
      assign casc_eff     = tmcnt_h[g][TMCNT_H_CASCADE];
      assign casc_tick[g] = enable[g] & casc_eff & ovf_q[g-1] & ~start[g] & ~frz;
      assign unused_bits  = ^{tmcnt_h[g][15:8], tmcnt_h[g][5:3]};
    end

    timer_prescaler #(.PRESC_W(PRESC_W)) u_presc (
      .clock_16   (clock_16),
      .reset      (reset),
      .enable     (enable[g] & ~casc_eff),
      .start      (start[g]),
      .psel       (psel),
      .hold       (frz),
      .presc_tick (presc_tick[g])
    );

    assign tick[g] = presc_tick[g] | casc_tick[g];
    // Not gated by enable: an overflow landing on the disable cycle still interrupts.
    assign irq[g]  = ovf_q[g] & irq_en & ~frz;
  end

endmodule
